uart_rx: RTL and testbench

UART receiver for the stopwatch/watch serial link, complementing the existing transmitter on the same shared `baud_tick` (8× oversampled bit rate). It synchronizes the asynchronous `rx` line and detects the start-bit falling edge. It mid-bit samples 8 data bits (LSB first) and the stop bit, then presents the received byte with a one-cycle done pulse. It feeds the command decoder/FIFO on the host-input path.

---
 rtl/uart_rx.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver driven by the shared oversampled baud_tick.
// Synchronizes rx, detects the start-bit falling edge, mid-bit samples
// 8 data bits (LSB first) and the stop bit, and reports the received byte
// with a one-cycle done pulse.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> start + 8 data + even parity + stop, o_parity_err checked
//   undefined -> start + 8 data + stop, o_parity_err tied to 0
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | line idle, waiting for a falling edge on rx_s
// START  | counting to mid start bit, rejecting glitches
// DATA   | sampling 8 data bits at one-bit intervals, LSB first
// PARITY | sampling the parity bit (only with UART_RX_PARITY_EN)
// STOP   | sampling the stop bit, then publishing byte and flags
module uart_rx #(
  parameter int OVERSAMPLE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_done,
  output logic       o_rx_busy,
  output logic       o_frame_err,
  output logic       o_parity_err
);

  localparam int BW = $clog2(OVERSAMPLE);
  localparam logic [BW-1:0] B_LAST = BW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_HALF = BW'(OVERSAMPLE / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state;
  logic            rx_m;
  logic            rx_s;
  logic            rx_s_d;
  logic [BW-1:0]   b_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            fall;

`ifdef UART_RX_PARITY_EN
  logic            par_bit;
`endif

  // two-flop synchronizer plus one delay flop for edge detection; idles high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_m   <= rx;
      rx_s   <= rx_m;
      rx_s_d <= rx_s;
    end
  end

  assign fall = rx_s_d & ~rx_s;

  // receive state machine with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      b_cnt       <= '0;
      bit_cnt     <= 3'd0;
      shift_reg   <= 8'h00;
      o_rx_data   <= 8'h00;
      o_rx_done   <= 1'b0;
      o_rx_busy   <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      o_rx_done <= 1'b0;
      case (state)
        IDLE: begin
          b_cnt   <= '0;
          bit_cnt <= 3'd0;
          if (fall) begin
            state     <= START;
            o_rx_busy <= 1'b1;
          end
        end

        START: begin
          if (baud_tick) begin
            if (b_cnt == B_HALF) begin
              b_cnt <= '0;
              if (!rx_s) begin
                state <= DATA;
              end else begin
                state     <= IDLE;
                o_rx_busy <= 1'b0;
              end
            end else begin
              b_cnt <= b_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (baud_tick) begin
            if (b_cnt == B_LAST) begin
              b_cnt     <= '0;
              shift_reg <= {rx_s, shift_reg[7:1]};
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              b_cnt <= b_cnt + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_tick) begin
            if (b_cnt == B_LAST) begin
              b_cnt   <= '0;
              par_bit <= rx_s;
              state   <= STOP;
            end else begin
              b_cnt <= b_cnt + 1'b1;
            end
          end
        end
`endif

        STOP: begin
          if (baud_tick) begin
            if (b_cnt == B_LAST) begin
              b_cnt       <= '0;
              bit_cnt     <= 3'd0;
              o_rx_data   <= shift_reg;
              o_frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
              o_parity_err <= (^shift_reg) ^ par_bit;
`endif
              o_rx_done   <= 1'b1;
              // an edge detected in this very cycle would be gone by the
              // first IDLE cycle, so it starts the next frame directly
              if (fall) begin
                state     <= START;
                o_rx_busy <= 1'b1;
              end else begin
                state     <= IDLE;
                o_rx_busy <= 1'b0;
              end
            end else begin
              b_cnt <= b_cnt + 1'b1;
            end
          end
        end

        default: begin
          state     <= IDLE;
          o_rx_busy <= 1'b0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames for uart_rx, checked against
// a frame-level reference model (byte in, byte/flags out).
module tb_uart_rx;

  localparam int OS      = 8;
  localparam int TDIV    = 10;
  localparam int BIT_CLK = OS * TDIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] o_rx_data;
  logic       o_rx_done;
  logic       o_rx_busy;
  logic       o_frame_err;
  logic       o_parity_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } rec_t;

  rec_t got[$];
  logic prev_done = 1'b0;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk          (clk),
    .rst          (rst),
    .baud_tick    (baud_tick),
    .rx           (rx),
    .o_rx_data    (o_rx_data),
    .o_rx_done    (o_rx_done),
    .o_rx_busy    (o_rx_busy),
    .o_frame_err  (o_frame_err),
    .o_parity_err (o_parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // free-running tick: one clk high every TDIV clocks
  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      baud_tick = (c == TDIV - 1);
      c = (c == TDIV - 1) ? 0 : c + 1;
    end
  end

  // collect every done pulse; done never on consecutive cycles, busy low with done
  always @(negedge clk) begin
    if (o_rx_done) begin
      chk("done_width", {31'd0, prev_done}, 32'd0);
      chk("busy_at_done", {31'd0, o_rx_busy}, 32'd0);
      got.push_back('{o_rx_data, o_frame_err, o_parity_err});
    end
    prev_done = o_rx_done;
  end

  function automatic logic exp_pe(input logic [7:0] d, input logic par);
`ifdef UART_RX_PARITY_EN
    return (^d) ^ par;
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`endif
    drive_bit(stop);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic fe, input logic pe);
    rec_t r;
    int n;
    n = 0;
    while (got.size() == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_present"}, {31'd0, got.size() != 0}, 32'd1);
    if (got.size() != 0) begin
      r = got.pop_front();
      chk({tag, "_data"}, {24'd0, r.d}, {24'd0, d});
      chk({tag, "_ferr"}, {31'd0, r.fe}, {31'd0, fe});
      chk({tag, "_perr"}, {31'd0, r.pe}, {31'd0, pe});
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"}, {24'd0, o_rx_data}, 32'd0);
    chk({tag, "_done"}, {31'd0, o_rx_done}, 32'd0);
    chk({tag, "_busy"}, {31'd0, o_rx_busy}, 32'd0);
    chk({tag, "_ferr"}, {31'd0, o_frame_err}, 32'd0);
    chk({tag, "_perr"}, {31'd0, o_parity_err}, 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    logic       par;
    int         gap;

    rst = 1'b0;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // single frame
    d = 8'h55;
    send_frame(d, 1'b1, ^d);
    expect_frame("f55", d, 1'b0, 1'b0);
    chk("f55_busy_after", {31'd0, o_rx_busy}, 32'd0);

    // back-to-back frames, no idle gap
    d = 8'hA3;
    send_frame(d, 1'b1, ^d);
    expect_frame("fA3", d, 1'b0, 1'b0);
    d = 8'h0F;
    send_frame(d, 1'b1, ^d);
    expect_frame("f0F", d, 1'b0, 1'b0);
    repeat (BIT_CLK) @(negedge clk);

    // start-bit glitch of two ticks
    rx = 1'b0;
    repeat (2 * TDIV) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLK) @(negedge clk);
    chk("glitch_no_done", got.size(), 32'd0);
    chk("glitch_busy", {31'd0, o_rx_busy}, 32'd0);
    chk("glitch_data_held", {24'd0, o_rx_data}, 32'h0F);

    // framing error followed by a long break
    d = 8'hC4;
    send_frame(d, 1'b0, ^d);
    expect_frame("fC4", d, 1'b1, 1'b0);
    rx = 1'b0;
    repeat (20 * BIT_CLK) @(negedge clk);
    chk("break_no_frames", got.size(), 32'd0);
    chk("break_busy", {31'd0, o_rx_busy}, 32'd0);
    rx = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    d = 8'h81;
    send_frame(d, 1'b1, ^d);
    expect_frame("after_break", d, 1'b0, 1'b0);

    // reset in the middle of data bit 4
    d = 8'h96;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (BIT_CLK / 2) @(negedge clk);
    chk("midframe_busy", {31'd0, o_rx_busy}, 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("midreset");
    rx = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    chk("no_stale_done", got.size(), 32'd0);
    d = 8'h3C;
    send_frame(d, 1'b1, ^d);
    expect_frame("f3C", d, 1'b0, 1'b0);
    repeat (BIT_CLK) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    d = 8'h07;
    send_frame(d, 1'b1, 1'b1);
    expect_frame("par_ok", d, 1'b0, 1'b0);
    send_frame(d, 1'b1, 1'b0);
    expect_frame("par_bad", d, 1'b0, 1'b1);
    repeat (BIT_CLK) @(negedge clk);
`endif

    // randomized frames with random gaps, occasional bad stop/parity
    for (int k = 0; k < 12; k++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      par  = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
      send_frame(d, stop, par);
      expect_frame("rand", d, ~stop, exp_pe(d, par));
      gap = stop ? int'($urandom_range(0, 100)) : BIT_CLK + int'($urandom_range(0, 50));
      rx = 1'b1;
      repeat (gap) @(negedge clk);
    end

    repeat (2 * BIT_CLK) @(negedge clk);
    chk("no_spurious", got.size(), 32'd0);
    chk("final_busy", {31'd0, o_rx_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
